// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared slice width and sequencer state encoding
// Purpose: constants and types shared by the vedic adder path.
// Ports: none (package).
package vedic_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_8bit.sv
// rtl/fa_8bit.sv - 8-bit ripple-carry adder slice
// Purpose: one combinational 8-bit ripple slice, time-shared by add_seq_ctrl.
// Ports:
//   a, b  in  8  slice operands
//   cin   in  1  carry into bit 0
//   sum   out 8  slice sum
//   cout  out 1  carry out of bit 7
module fa_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - byte-serial W-bit adder sequencer around one fa_8bit
// Purpose: adds two W-bit operands one 8-bit slice per clock, LSB first,
//   carrying between slices in a register; valid/ready on both sides.
// Ports:
//   clk, rst              in      clock (rising), async active-high reset
//   in_valid / in_ready   in/out  operand handshake (a, b, cin)
//   a, b                  in  W   operands
//   cin                   in  1   carry into slice 0
//   out_valid / out_ready out/in  result handshake
//   sum                   out W   a+b+cin mod 2^W
//   cout                  out 1   carry out of bit W-1
//   ovf                   out 1   signed overflow
//   busy                  out 1   sequencer not idle
module add_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int NSLICE = W / SLICE_W;
  localparam int KW     = $clog2(NSLICE) + 1;

  state_t         state, state_next;
  logic [W-1:0]   opa, opb, sum_r;
  logic           carry, cout_r, ovf_r;
  logic           sign_a, sign_b;
  logic [KW-1:0]  k;
  logic [SLICE_W-1:0] slice_sum;
  logic           slice_cout;
  logic           last_slice;

  fa_8bit u_fa (
    .a    (opa[SLICE_W-1:0]),
    .b    (opb[SLICE_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_slice = (k == KW'(NSLICE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      k      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa    <= a;
            opb    <= b;
            carry  <= cin;
            k      <= '0;
            // Overflow is judged on the operand signs as accepted, since the
            // live inputs may change while the slices are being processed.
            sign_a <= a[W-1];
            sign_b <= b[W-1];
          end
        end
        RUN: begin
          opa   <= opa >> SLICE_W;
          opb   <= opb >> SLICE_W;
          // New slice enters at the top; after NSLICE shifts slice 0 sits at the bottom.
          sum_r <= (sum_r >> SLICE_W) | (W'(slice_sum) << (W - SLICE_W));
          carry <= slice_cout;
          k     <= k + KW'(1);
          if (last_slice) begin
            cout_r <= slice_cout;
            ovf_r  <= (sign_a == sign_b) && (slice_sum[SLICE_W-1] != sign_a);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - directed and randomised checks of add_seq_ctrl at W=32/8/16
module tb_add_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: W=32, 1: W=8, 2: W=16
  logic        in_valid_v  [3];
  logic        out_ready_v [3];
  logic        cin_v       [3];
  logic [31:0] a_v         [3];
  logic [31:0] b_v         [3];
  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic        cout_v      [3];
  logic        ovf_v       [3];
  logic        busy_v      [3];
  logic [31:0] sum32;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  int n_cmp = 0;
  int n_err = 0;

  add_seq_ctrl #(.W(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum32), .cout(cout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0])
  );

  add_seq_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum8), .cout(cout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1])
  );

  add_seq_ctrl #(.W(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2][15:0]), .b(b_v[2][15:0]), .cin(cin_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum16), .cout(cout_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2])
  );

  function automatic logic [31:0] sum_of(input int idx);
    if (idx == 1) return {24'h0, sum8};
    if (idx == 2) return {16'h0, sum16};
    return sum32;
  endfunction

  // Accept one operation on the W=32 instance and wait for out_valid without popping.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                       output logic [31:0] s, output logic co, output logic ov,
                       output int lat);
    @(negedge clk);
    a_v[0] = a; b_v[0] = b; cin_v[0] = c; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    lat = 1;
    while (!out_valid_v[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s = sum32; co = cout_v[0]; ov = ovf_v[0];
  endtask

  task automatic pop;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready_v[i] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", i, in_ready_v[i]); end
      n_cmp++; if (out_valid_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", i, out_valid_v[i]); end
      n_cmp++; if (busy_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy_v[i]); end
      n_cmp++; if (cout_v[i] !== 1'b0 || ovf_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_cout_ovf[%0d] got=%b%b exp=00", i, cout_v[i], ovf_v[i]); end
      n_cmp++; if (sum_of(i) !== 32'h0) begin n_err++; $display("FAIL reset_sum[%0d] got=%h exp=0", i, sum_of(i)); end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready_v[0]); end
    n_cmp++; if (out_valid_v[0] !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid_v[0]); end
  endtask

  task automatic test_carry;
    logic [31:0] s; logic co, ov; int lat;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, s, co, ov, lat);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL carry_latency got=%0d exp=5", lat); end
    n_cmp++; if (s !== 32'h0000_0100) begin n_err++; $display("FAIL carry_sum got=%h exp=00000100", s); end
    n_cmp++; if (co !== 1'b0 || ov !== 1'b0) begin n_err++; $display("FAIL carry_cout_ovf got=%b%b exp=00", co, ov); end
    pop();
    n_cmp++; if (out_valid_v[0] !== 1'b0) begin n_err++; $display("FAIL carry_pop_out_valid got=%b exp=0", out_valid_v[0]); end
    n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_err++; $display("FAIL carry_pop_in_ready got=%b exp=1", in_ready_v[0]); end
  endtask

  task automatic test_extremes;
    logic [31:0] s; logic co, ov; int lat;
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, s, co, ov, lat);
    n_cmp++; if (s !== 32'h0) begin n_err++; $display("FAIL wrap_sum got=%h exp=00000000", s); end
    n_cmp++; if (co !== 1'b1) begin n_err++; $display("FAIL wrap_cout got=%b exp=1", co); end
    n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL wrap_ovf got=%b exp=0", ov); end
    pop();
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, s, co, ov, lat);
    n_cmp++; if (s !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_sum got=%h exp=80000000", s); end
    n_cmp++; if (co !== 1'b0) begin n_err++; $display("FAIL ovf_cout got=%b exp=0", co); end
    n_cmp++; if (ov !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", ov); end
    pop();
  endtask

  task automatic test_backpressure;
    logic [31:0] s; logic co, ov; int lat;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, s, co, ov, lat);
    n_cmp++; if (s !== 32'h2345_6789) begin n_err++; $display("FAIL bp_sum got=%h exp=23456789", s); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a_v[0] = 32'hDEAD_BEEF; b_v[0] = 32'h0BAD_F00D; cin_v[0] = 1'b1; in_valid_v[0] = 1'b1;
      end else begin
        in_valid_v[0] = 1'b0;
      end
      @(negedge clk);
      n_cmp++; if (out_valid_v[0] !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid_v[0]); end
      n_cmp++; if (sum32 !== 32'h2345_6789) begin n_err++; $display("FAIL bp_hold_sum cyc=%0d got=%h exp=23456789", i, sum32); end
      n_cmp++; if (in_ready_v[0] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready_v[0]); end
    end
    in_valid_v[0] = 1'b0;
    pop();
    n_cmp++; if (out_valid_v[0] !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", out_valid_v[0]); end
    n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready_v[0]); end
    @(negedge clk);
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL bp_ignored_pulse busy got=%b exp=0", busy_v[0]); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] s; logic co, ov; int lat; logic seen;
    @(negedge clk);
    a_v[0] = 32'hAAAA_5555; b_v[0] = 32'h1357_9BDF; cin_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy_v[0]); end
    n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready_v[0]); end
    n_cmp++; if (sum32 !== 32'h0) begin n_err++; $display("FAIL midrst_sum got=%h exp=0", sum32); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_v[0]) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_out_valid got=%b exp=0", seen); end
    do_op(32'h1, 32'h2, 1'b0, s, co, ov, lat);
    n_cmp++; if (s !== 32'h3) begin n_err++; $display("FAIL midrst_after_sum got=%h exp=00000003", s); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL midrst_after_latency got=%0d exp=5", lat); end
    pop();
  endtask

  task automatic test_back_to_back(input int idx, input int w, input int n);
    logic [32:0] full;
    logic [31:0] mask, ea, eb, es;
    logic        ec, eco, eov;
    logic        got;
    int          cyc;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ea = $urandom & mask;
      eb = $urandom & mask;
      ec = 1'($urandom_range(0, 1));
      full = {1'b0, ea} + {1'b0, eb} + {32'h0, ec};
      es  = full[31:0] & mask;
      eco = full[w];
      eov = (ea[w-1] == eb[w-1]) && (es[w-1] != ea[w-1]);
      a_v[idx] = ea; b_v[idx] = eb; cin_v[idx] = ec; in_valid_v[idx] = 1'b1;
      n_cmp++; if (in_ready_v[idx] !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready w=%0d t=%0d got=%b exp=1", w, t, in_ready_v[idx]); end
      @(negedge clk);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 60) begin
        in_valid_v[idx] = 1'($urandom_range(0, 1));
        a_v[idx] = $urandom; b_v[idx] = $urandom; cin_v[idx] = 1'($urandom_range(0, 1));
        out_ready_v[idx] = 1'($urandom_range(0, 1));
        if (out_valid_v[idx] && out_ready_v[idx]) begin
          got = 1'b1;
          n_cmp++; if (sum_of(idx) !== es) begin n_err++; $display("FAIL b2b_sum w=%0d t=%0d a=%h b=%h cin=%b got=%h exp=%h", w, t, ea, eb, ec, sum_of(idx), es); end
          n_cmp++; if (cout_v[idx] !== eco) begin n_err++; $display("FAIL b2b_cout w=%0d t=%0d got=%b exp=%b", w, t, cout_v[idx], eco); end
          n_cmp++; if (ovf_v[idx] !== eov) begin n_err++; $display("FAIL b2b_ovf w=%0d t=%0d got=%b exp=%b", w, t, ovf_v[idx], eov); end
        end
        @(negedge clk);
        cyc++;
      end
      in_valid_v[idx] = 1'b0;
      out_ready_v[idx] = 1'b0;
      if (!got) begin
        n_cmp++; n_err++;
        $display("FAIL b2b_timeout w=%0d t=%0d got=no_result exp=result", w, t);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0; cin_v[i] = 1'b0;
      a_v[i] = 32'h0; b_v[i] = 32'h0;
    end
    test_reset();
    test_carry();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back(0, 32, 1000);
    test_back_to_back(1, 8, 1000);
    test_back_to_back(2, 16, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
